// File: rtl/decode_stage_pipe_if.sv
// ID/EX side of decode_stage_pipe: valid/ready handshake plus the registered
// operands, indices and control that the execute stage consumes.
interface decode_stage_pipe_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      EX_ready_i;
  logic                      EX_valid_o;
  logic [DATA_WIDTH-1:0]     EX_pc_o;
  logic [DATA_WIDTH-1:0]     EX_rs1_data_o;
  logic [DATA_WIDTH-1:0]     EX_rs2_data_o;
  logic [DATA_WIDTH-1:0]     EX_imm_o;
  logic [REG_ADDR_WIDTH-1:0] EX_rs1_addr_o;
  logic [REG_ADDR_WIDTH-1:0] EX_rs2_addr_o;
  logic [REG_ADDR_WIDTH-1:0] EX_rd_addr_o;
  logic [2:0]                EX_funct3_o;
  logic [1:0]                EX_WBSel_o;
  logic [3:0]                EX_ALUOp_o;
  logic                      EX_ALUSrc1_o;
  logic                      EX_ALUSrc2_o;
  logic                      EX_MemRead_o;
  logic                      EX_MemWrite_o;
  logic                      EX_RegWrite_o;

  modport master (
    input  EX_ready_i,
    output EX_valid_o, EX_pc_o, EX_rs1_data_o, EX_rs2_data_o, EX_imm_o,
           EX_rs1_addr_o, EX_rs2_addr_o, EX_rd_addr_o, EX_funct3_o,
           EX_WBSel_o, EX_ALUOp_o, EX_ALUSrc1_o, EX_ALUSrc2_o,
           EX_MemRead_o, EX_MemWrite_o, EX_RegWrite_o
  );

  modport slave (
    output EX_ready_i,
    input  EX_valid_o, EX_pc_o, EX_rs1_data_o, EX_rs2_data_o, EX_imm_o,
           EX_rs1_addr_o, EX_rs2_addr_o, EX_rd_addr_o, EX_funct3_o,
           EX_WBSel_o, EX_ALUOp_o, EX_ALUSrc1_o, EX_ALUSrc2_o,
           EX_MemRead_o, EX_MemWrite_o, EX_RegWrite_o
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// Hazard-aware RV32I/RV32E decode stage with built-in ID/EX register and ID branch resolution.
// Define DECODE_WB_BYPASS_EN to forward a same-cycle WB write into the operand reads.
module decode_stage_pipe #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_REGS       = 2**REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ID_valid_i,
  output logic                      ID_ready_o,
  input  logic [31:0]               ID_instruction_i,
  input  logic [DATA_WIDTH-1:0]     ID_pc_i,
  input  logic                      WB_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] WB_wr_addr_i,
  input  logic [DATA_WIDTH-1:0]     WB_wr_data_i,
  input  logic                      MEM_RegWrite_i,
  input  logic [REG_ADDR_WIDTH-1:0] MEM_rd_addr_i,
  output logic                      ID_PCSrc_o,
  output logic [DATA_WIDTH-1:0]     ID_target_addr_o,
  output logic                      ID_flush_o,
  decode_stage_pipe_if.master       ex
);
  localparam int RA = REG_ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2} wb_sel_e;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_dec = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_dec = ALU_SLL;
      3'b010:  alu_dec = ALU_SLT;
      3'b011:  alu_dec = ALU_SLTU;
      3'b100:  alu_dec = ALU_XOR;
      3'b101:  alu_dec = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_dec = ALU_OR;
      default: alu_dec = ALU_AND;
    endcase
  endfunction

  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          funct7_b5;
  logic [RA-1:0] rd, rs1, rs2;

  assign opcode    = ID_instruction_i[6:0];
  assign funct3    = ID_instruction_i[14:12];
  assign funct7_b5 = ID_instruction_i[30];
  assign rd        = ID_instruction_i[7 +: RA];
  assign rs1       = ID_instruction_i[15 +: RA];
  assign rs2       = ID_instruction_i[20 +: RA];

  // main control
  logic    is_branch, is_jal, is_jalr, uses_rs1, uses_rs2;
  logic    reg_write, mem_read, mem_write, alu_src1, alu_src2;
  wb_sel_e wb_sel;
  alu_op_e alu_op;
  logic [2:0] imm_type;

  always_comb begin
    is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    uses_rs1  = 1'b0; uses_rs2 = 1'b0;
    reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    alu_src1  = 1'b0; alu_src2 = 1'b0;
    wb_sel    = WB_ALU; alu_op = ALU_ADD; imm_type = IMM_I;
    case (opcode)
      OPC_LUI:    begin reg_write = 1'b1; alu_src2 = 1'b1; alu_op = ALU_PASSB; imm_type = IMM_U; end
      OPC_AUIPC:  begin reg_write = 1'b1; alu_src1 = 1'b1; alu_src2 = 1'b1; imm_type = IMM_U; end
      OPC_JAL:    begin is_jal = 1'b1; reg_write = 1'b1; alu_src1 = 1'b1; alu_src2 = 1'b1;
                        wb_sel = WB_PC4; imm_type = IMM_J; end
      OPC_JALR:   begin is_jalr = 1'b1; uses_rs1 = 1'b1; reg_write = 1'b1; alu_src2 = 1'b1;
                        wb_sel = WB_PC4; end
      OPC_BRANCH: begin is_branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm_type = IMM_B; end
      OPC_LOAD:   begin uses_rs1 = 1'b1; reg_write = 1'b1; mem_read = 1'b1; alu_src2 = 1'b1;
                        wb_sel = WB_MEM; end
      OPC_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; mem_write = 1'b1; alu_src2 = 1'b1;
                        imm_type = IMM_S; end
      OPC_OPIMM:  begin uses_rs1 = 1'b1; reg_write = 1'b1; alu_src2 = 1'b1;
                        alu_op = alu_dec(funct3, funct7_b5 & (funct3 == 3'b101)); end
      OPC_OP:     begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; reg_write = 1'b1;
                        alu_op = alu_dec(funct3, funct7_b5); end
      default: ;
    endcase
  end

  // immediate select + generate
  logic [31:0]   imm32;
  logic [DW-1:0] imm;

  always_comb begin
    case (imm_type)
      IMM_S:   imm32 = {{20{ID_instruction_i[31]}}, ID_instruction_i[31:25], ID_instruction_i[11:7]};
      IMM_B:   imm32 = {{19{ID_instruction_i[31]}}, ID_instruction_i[31], ID_instruction_i[7],
                        ID_instruction_i[30:25], ID_instruction_i[11:8], 1'b0};
      IMM_U:   imm32 = {ID_instruction_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{ID_instruction_i[31]}}, ID_instruction_i[31], ID_instruction_i[19:12],
                        ID_instruction_i[20], ID_instruction_i[30:21], 1'b0};
      default: imm32 = {{20{ID_instruction_i[31]}}, ID_instruction_i[31:20]};
    endcase
  end

  assign imm = DW'(signed'(imm32));

  // register file; x0 is never written so it reads back zero
  logic [DW-1:0] rf [NUM_REGS];
  logic [DW-1:0] rs1_rf, rs2_rf, rs1_d, rs2_d;
  logic          wb_hit1, wb_hit2, wb_haz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (WB_we_i && WB_wr_addr_i != '0) begin
      rf[WB_wr_addr_i] <= WB_wr_data_i;
    end
  end

  assign rs1_rf  = (rs1 == '0) ? '0 : rf[rs1];
  assign rs2_rf  = (rs2 == '0) ? '0 : rf[rs2];
  assign wb_hit1 = WB_we_i && (WB_wr_addr_i == rs1) && (rs1 != '0);
  assign wb_hit2 = WB_we_i && (WB_wr_addr_i == rs2) && (rs2 != '0);

`ifdef DECODE_WB_BYPASS_EN
  assign rs1_d  = wb_hit1 ? WB_wr_data_i : rs1_rf;
  assign rs2_d  = wb_hit2 ? WB_wr_data_i : rs2_rf;
  assign wb_haz = 1'b0;
`else
  assign rs1_d  = rs1_rf;
  assign rs2_d  = rs2_rf;
  assign wb_haz = (wb_hit1 & uses_rs1) | (wb_hit2 & uses_rs2);
`endif

  // branch compare + determination
  logic br_eq, br_lt, br_ltu, br_cond, taken;

  assign br_eq  = (rs1_d == rs2_d);
  assign br_lt  = ($signed(rs1_d) < $signed(rs2_d));
  assign br_ltu = (rs1_d < rs2_d);

  always_comb begin
    case (funct3)
      3'b000:  br_cond = br_eq;
      3'b001:  br_cond = !br_eq;
      3'b100:  br_cond = br_lt;
      3'b101:  br_cond = !br_lt;
      3'b110:  br_cond = br_ltu;
      3'b111:  br_cond = !br_ltu;
      default: br_cond = 1'b0;
    endcase
  end

  assign taken = is_jal | is_jalr | (is_branch & br_cond);

  // hazards
  logic rs1_used, rs2_used, load_use, br_haz, hazard, load, bubble, accept;
  logic ex_prod1, ex_prod2, mem_prod1, mem_prod2;

  assign rs1_used  = uses_rs1 && (rs1 != '0);
  assign rs2_used  = uses_rs2 && (rs2 != '0);
  assign load_use  = ex.EX_valid_o && ex.EX_MemRead_o &&
                     (((rs1 != '0) && (ex.EX_rd_addr_o == rs1)) ||
                      ((rs2 != '0) && (ex.EX_rd_addr_o == rs2)));
  assign ex_prod1  = ex.EX_valid_o && ex.EX_RegWrite_o && (ex.EX_rd_addr_o == rs1);
  assign ex_prod2  = ex.EX_valid_o && ex.EX_RegWrite_o && (ex.EX_rd_addr_o == rs2);
  assign mem_prod1 = MEM_RegWrite_i && (MEM_rd_addr_i == rs1);
  assign mem_prod2 = MEM_RegWrite_i && (MEM_rd_addr_i == rs2);
  assign br_haz    = (is_branch | is_jalr) &&
                     ((rs1_used && (ex_prod1 || mem_prod1)) ||
                      (rs2_used && (ex_prod2 || mem_prod2)));
  assign hazard    = ID_valid_i & (load_use | br_haz | wb_haz);

  assign load       = !ex.EX_valid_o | ex.EX_ready_i;
  assign bubble     = hazard | !ID_valid_i;
  assign ID_ready_o = load & !hazard;
  assign accept     = ID_valid_i & ID_ready_o;

  // redirect
  logic [DW-1:0] jalr_sum;

  assign jalr_sum         = rs1_d + imm;
  assign ID_target_addr_o = is_jalr ? {jalr_sum[DW-1:1], 1'b0} : (ID_pc_i + imm);
  assign ID_PCSrc_o       = rst_n & accept & taken;
  assign ID_flush_o       = ID_PCSrc_o;

  // ID/EX register; a bubble only kills the side-effecting controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex.EX_valid_o    <= 1'b0;
      ex.EX_pc_o       <= '0;
      ex.EX_rs1_data_o <= '0;
      ex.EX_rs2_data_o <= '0;
      ex.EX_imm_o      <= '0;
      ex.EX_rs1_addr_o <= '0;
      ex.EX_rs2_addr_o <= '0;
      ex.EX_rd_addr_o  <= '0;
      ex.EX_funct3_o   <= '0;
      ex.EX_WBSel_o    <= WB_ALU;
      ex.EX_ALUOp_o    <= ALU_ADD;
      ex.EX_ALUSrc1_o  <= 1'b0;
      ex.EX_ALUSrc2_o  <= 1'b0;
      ex.EX_MemRead_o  <= 1'b0;
      ex.EX_MemWrite_o <= 1'b0;
      ex.EX_RegWrite_o <= 1'b0;
    end else if (load) begin
      if (bubble) begin
        ex.EX_valid_o    <= 1'b0;
        ex.EX_RegWrite_o <= 1'b0;
        ex.EX_MemRead_o  <= 1'b0;
        ex.EX_MemWrite_o <= 1'b0;
      end else begin
        ex.EX_valid_o    <= 1'b1;
        ex.EX_pc_o       <= ID_pc_i;
        ex.EX_rs1_data_o <= rs1_d;
        ex.EX_rs2_data_o <= rs2_d;
        ex.EX_imm_o      <= imm;
        ex.EX_rs1_addr_o <= rs1;
        ex.EX_rs2_addr_o <= rs2;
        ex.EX_rd_addr_o  <= rd;
        ex.EX_funct3_o   <= funct3;
        ex.EX_WBSel_o    <= wb_sel;
        ex.EX_ALUOp_o    <= alu_op;
        ex.EX_ALUSrc1_o  <= alu_src1;
        ex.EX_ALUSrc2_o  <= alu_src2;
        ex.EX_MemRead_o  <= mem_read;
        ex.EX_MemWrite_o <= mem_write;
        ex.EX_RegWrite_o <= reg_write;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: reset, hazards, redirects, backpressure, WB collision.
module tb_decode_stage_pipe;
  localparam logic [31:0] I_LW     = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADD    = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] I_BEQ    = 32'h00208863; // beq  x1,x2,+16
  localparam logic [31:0] I_JALR   = 32'h00408067; // jalr x0,4(x1)
  localparam logic [31:0] I_JAL    = 32'h0080006F; // jal  x0,+8
  localparam logic [31:0] I_ADDI1  = 32'h20300093; // addi x1,x0,0x203
  localparam logic [31:0] I_ADDI7  = 32'h00500393; // addi x7,x0,5
  localparam logic [31:0] I_ADDI8  = 32'h00900413; // addi x8,x0,9
  localparam logic [31:0] I_ADD43  = 32'h00018233; // add  x4,x3,x0
  localparam logic [31:0] I_ADD400 = 32'h00000233; // add  x4,x0,x0

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ID_valid, ID_ready;
  logic [31:0] instr, ID_pc;
  logic        WB_we;
  logic [4:0]  WB_addr;
  logic [31:0] WB_data;
  logic        MEM_rw;
  logic [4:0]  MEM_rd;
  logic        PCSrc, flush;
  logic [31:0] target;
  int          errors = 0;
  int          checks = 0;

  decode_stage_pipe_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) ex_if ();

  decode_stage_pipe #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .NUM_REGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_valid_i(ID_valid), .ID_ready_o(ID_ready),
    .ID_instruction_i(instr), .ID_pc_i(ID_pc),
    .WB_we_i(WB_we), .WB_wr_addr_i(WB_addr), .WB_wr_data_i(WB_data),
    .MEM_RegWrite_i(MEM_rw), .MEM_rd_addr_i(MEM_rd),
    .ID_PCSrc_o(PCSrc), .ID_target_addr_o(target), .ID_flush_o(flush),
    .ex(ex_if.master)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    ID_valid = 1'b1; instr = ins; ID_pc = pc;
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    ID_valid = 1'b0; WB_we = 1'b1; WB_addr = a; WB_data = d;
    @(negedge clk);
    WB_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; issue(I_JAL, 32'h20); ex_if.EX_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (ex_if.EX_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %h want 0", ex_if.EX_valid_o); end
    checks++; if (PCSrc !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL rst_pcsrc: got %b%b want 00", PCSrc, flush); end
    checks++; if ({ex_if.EX_pc_o, ex_if.EX_rs1_data_o, ex_if.EX_rs2_data_o, ex_if.EX_imm_o} !== 128'd0) begin
      errors++; $display("FAIL rst_data: got %h %h %h %h want 0", ex_if.EX_pc_o, ex_if.EX_rs1_data_o, ex_if.EX_rs2_data_o, ex_if.EX_imm_o); end
    checks++; if ({ex_if.EX_rs1_addr_o, ex_if.EX_rs2_addr_o, ex_if.EX_rd_addr_o, ex_if.EX_funct3_o, ex_if.EX_WBSel_o,
                   ex_if.EX_ALUOp_o, ex_if.EX_ALUSrc1_o, ex_if.EX_ALUSrc2_o, ex_if.EX_MemRead_o, ex_if.EX_MemWrite_o,
                   ex_if.EX_RegWrite_o} !== 29'd0) begin
      errors++; $display("FAIL rst_ctrl: got rs1=%h rs2=%h rd=%h f3=%h wb=%h alu=%h s1=%b s2=%b mr=%b mw=%b rw=%b want 0",
        ex_if.EX_rs1_addr_o, ex_if.EX_rs2_addr_o, ex_if.EX_rd_addr_o, ex_if.EX_funct3_o, ex_if.EX_WBSel_o, ex_if.EX_ALUOp_o,
        ex_if.EX_ALUSrc1_o, ex_if.EX_ALUSrc2_o, ex_if.EX_MemRead_o, ex_if.EX_MemWrite_o, ex_if.EX_RegWrite_o); end
    @(negedge clk);
    rst_n = 1'b1; issue(I_ADDI7, 32'h40);
    #1;
    checks++; if (ID_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b want 1", ID_ready); end
    @(negedge clk);
    checks++; if (ex_if.EX_valid_o !== 1'b1 || ex_if.EX_pc_o !== 32'h40) begin
      errors++; $display("FAIL rel_first: got v=%b pc=%h want v=1 pc=40", ex_if.EX_valid_o, ex_if.EX_pc_o); end
    checks++; if (ex_if.EX_imm_o !== 32'd5 || ex_if.EX_rd_addr_o !== 5'd7 || ex_if.EX_RegWrite_o !== 1'b1 || ex_if.EX_ALUSrc2_o !== 1'b1) begin
      errors++; $display("FAIL rel_fields: got imm=%h rd=%h rw=%b s2=%b want 5 7 1 1", ex_if.EX_imm_o, ex_if.EX_rd_addr_o,
        ex_if.EX_RegWrite_o, ex_if.EX_ALUSrc2_o); end
    ID_valid = 1'b0;
    @(negedge clk);
    checks++; if (ex_if.EX_valid_o !== 1'b0 || ex_if.EX_RegWrite_o !== 1'b0) begin
      errors++; $display("FAIL rel_bubble: got v=%b rw=%b want 0 0", ex_if.EX_valid_o, ex_if.EX_RegWrite_o); end
  endtask

  task automatic test_load_use();
    wb_write(5'd1, 32'd100);
    wb_write(5'd2, 32'd3);
    issue(I_LW, 32'h200);
    #1;
    checks++; if (ID_ready !== 1'b1) begin errors++; $display("FAIL lu_lw_ready: got %b want 1", ID_ready); end
    @(negedge clk);
    checks++; if (ex_if.EX_valid_o !== 1'b1 || ex_if.EX_MemRead_o !== 1'b1 || ex_if.EX_rd_addr_o !== 5'd5) begin
      errors++; $display("FAIL lu_lw_ex: got v=%b mr=%b rd=%h want 1 1 5", ex_if.EX_valid_o, ex_if.EX_MemRead_o, ex_if.EX_rd_addr_o); end
    issue(I_ADD, 32'h204);
    #1;
    checks++; if (ID_ready !== 1'b0) begin errors++; $display("FAIL lu_stall: got %b want 0", ID_ready); end
    @(negedge clk);
    checks++; if (ex_if.EX_valid_o !== 1'b0 || ex_if.EX_MemRead_o !== 1'b0) begin
      errors++; $display("FAIL lu_bubble: got v=%b mr=%b want 0 0", ex_if.EX_valid_o, ex_if.EX_MemRead_o); end
    #1;
    checks++; if (ID_ready !== 1'b1) begin errors++; $display("FAIL lu_resume: got %b want 1", ID_ready); end
    @(negedge clk);
    checks++; if (ex_if.EX_valid_o !== 1'b1 || ex_if.EX_rs1_addr_o !== 5'd5 || ex_if.EX_pc_o !== 32'h204 ||
                  ex_if.EX_rs2_data_o !== 32'd3) begin
      errors++; $display("FAIL lu_add: got v=%b rs1=%h pc=%h rs2d=%h want 1 5 204 3", ex_if.EX_valid_o,
        ex_if.EX_rs1_addr_o, ex_if.EX_pc_o, ex_if.EX_rs2_data_o); end
    ID_valid = 1'b0;
  endtask

  task automatic test_branch();
    wb_write(5'd1, 32'd7);
    wb_write(5'd2, 32'd7);
    issue(I_BEQ, 32'h100);
    #1;
    checks++; if (PCSrc !== 1'b1 || flush !== 1'b1 || target !== 32'h110) begin
      errors++; $display("FAIL beq_taken: got pcsrc=%b flush=%b tgt=%h want 1 1 110", PCSrc, flush, target); end
    @(negedge clk);
    ID_valid = 1'b0;
    #1;
    checks++; if (PCSrc !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL beq_pulse: got %b%b want 00", PCSrc, flush); end
    wb_write(5'd2, 32'd8);
    issue(I_BEQ, 32'h100);
    #1;
    checks++; if (PCSrc !== 1'b0 || ID_ready !== 1'b1) begin
      errors++; $display("FAIL beq_not_taken: got pcsrc=%b ready=%b want 0 1", PCSrc, ID_ready); end
    @(negedge clk);
    ID_valid = 1'b0;
  endtask

  task automatic test_jalr();
    wb_write(5'd1, 32'h203);
    issue(I_JALR, 32'h300);
    #1;
    checks++; if (PCSrc !== 1'b1 || target !== 32'h206) begin
      errors++; $display("FAIL jalr_tgt: got pcsrc=%b tgt=%h want 1 206", PCSrc, target); end
    @(negedge clk);
    ID_valid = 1'b0;
    @(negedge clk);
    issue(I_ADDI1, 32'h310);
    @(negedge clk);
    issue(I_JALR, 32'h314);
    #1;
    checks++; if (ID_ready !== 1'b0 || PCSrc !== 1'b0) begin
      errors++; $display("FAIL jalr_stall_ex: got ready=%b pcsrc=%b want 0 0", ID_ready, PCSrc); end
    @(negedge clk);
    MEM_rw = 1'b1; MEM_rd = 5'd1;
    #1;
    checks++; if (ID_ready !== 1'b0 || PCSrc !== 1'b0 || ex_if.EX_valid_o !== 1'b0) begin
      errors++; $display("FAIL jalr_stall_mem: got ready=%b pcsrc=%b v=%b want 0 0 0", ID_ready, PCSrc, ex_if.EX_valid_o); end
    @(negedge clk);
    MEM_rw = 1'b0; MEM_rd = 5'd0;
    #1;
    checks++; if (ID_ready !== 1'b1 || PCSrc !== 1'b1 || target !== 32'h206) begin
      errors++; $display("FAIL jalr_redirect: got ready=%b pcsrc=%b tgt=%h want 1 1 206", ID_ready, PCSrc, target); end
    @(negedge clk);
    ID_valid = 1'b0;
    checks++; if (ex_if.EX_valid_o !== 1'b1 || ex_if.EX_pc_o !== 32'h314 || ex_if.EX_WBSel_o !== 2'd2) begin
      errors++; $display("FAIL jalr_ex: got v=%b pc=%h wb=%h want 1 314 2", ex_if.EX_valid_o, ex_if.EX_pc_o, ex_if.EX_WBSel_o); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    issue(I_ADDI7, 32'h600);
    #1;
    checks++; if (ID_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b want 1", ID_ready); end
    @(negedge clk);
    checks++; if (ex_if.EX_pc_o !== 32'h600) begin errors++; $display("FAIL b2b_pc0: got %h want 600", ex_if.EX_pc_o); end
    issue(I_ADDI8, 32'h604);
    #1;
    checks++; if (ID_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1: got %b want 1", ID_ready); end
    @(negedge clk);
    checks++; if (ex_if.EX_valid_o !== 1'b1 || ex_if.EX_pc_o !== 32'h604 || ex_if.EX_rd_addr_o !== 5'd8) begin
      errors++; $display("FAIL b2b_pc1: got v=%b pc=%h rd=%h want 1 604 8", ex_if.EX_valid_o, ex_if.EX_pc_o, ex_if.EX_rd_addr_o); end
    ID_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    issue(I_ADDI7, 32'h400);
    @(negedge clk);
    issue(I_ADDI8, 32'h404); ex_if.EX_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ex_if.EX_valid_o !== 1'b1 || ex_if.EX_pc_o !== 32'h400 || ex_if.EX_imm_o !== 32'd5 ||
                    ex_if.EX_rd_addr_o !== 5'd7 || ID_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b pc=%h imm=%h rd=%h ready=%b want 1 400 5 7 0", i,
          ex_if.EX_valid_o, ex_if.EX_pc_o, ex_if.EX_imm_o, ex_if.EX_rd_addr_o, ID_ready); end
      @(negedge clk);
    end
    ex_if.EX_ready_i = 1'b1;
    #1;
    checks++; if (ID_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %b want 1", ID_ready); end
    @(negedge clk);
    checks++; if (ex_if.EX_pc_o !== 32'h404 || ex_if.EX_imm_o !== 32'd9 || ex_if.EX_rd_addr_o !== 5'd8) begin
      errors++; $display("FAIL bp_next: got pc=%h imm=%h rd=%h want 404 9 8", ex_if.EX_pc_o, ex_if.EX_imm_o, ex_if.EX_rd_addr_o); end
    ID_valid = 1'b0;
  endtask

  task automatic test_wb_collision();
    wb_write(5'd3, 32'h1111);
    issue(I_ADD43, 32'h500); WB_we = 1'b1; WB_addr = 5'd3; WB_data = 32'hDEAD;
    #1;
`ifdef DECODE_WB_BYPASS_EN
    checks++; if (ID_ready !== 1'b1) begin errors++; $display("FAIL wb_ready: got %b want 1", ID_ready); end
    @(negedge clk);
    WB_we = 1'b0; ID_valid = 1'b0;
`else
    checks++; if (ID_ready !== 1'b0) begin errors++; $display("FAIL wb_stall: got %b want 0", ID_ready); end
    @(negedge clk);
    WB_we = 1'b0;
    checks++; if (ex_if.EX_valid_o !== 1'b0) begin errors++; $display("FAIL wb_bubble: got %b want 0", ex_if.EX_valid_o); end
    #1;
    checks++; if (ID_ready !== 1'b1) begin errors++; $display("FAIL wb_resume: got %b want 1", ID_ready); end
    @(negedge clk);
    ID_valid = 1'b0;
`endif
    checks++; if (ex_if.EX_valid_o !== 1'b1 || ex_if.EX_rs1_data_o !== 32'hDEAD) begin
      errors++; $display("FAIL wb_data: got v=%b rs1d=%h want 1 dead", ex_if.EX_valid_o, ex_if.EX_rs1_data_o); end
    @(negedge clk);
    issue(I_ADD400, 32'h510); WB_we = 1'b1; WB_addr = 5'd0; WB_data = 32'hFFFF;
    #1;
    checks++; if (ID_ready !== 1'b1) begin errors++; $display("FAIL wb_x0_ready: got %b want 1", ID_ready); end
    @(negedge clk);
    WB_we = 1'b0; ID_valid = 1'b0;
    checks++; if (ex_if.EX_valid_o !== 1'b1 || ex_if.EX_rs1_data_o !== 32'd0 || ex_if.EX_rs2_data_o !== 32'd0) begin
      errors++; $display("FAIL wb_x0: got v=%b rs1d=%h rs2d=%h want 1 0 0", ex_if.EX_valid_o, ex_if.EX_rs1_data_o,
        ex_if.EX_rs2_data_o); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    issue(I_ADDI7, 32'h700);
    @(negedge clk);
    ID_valid = 1'b0; ex_if.EX_ready_i = 1'b0;
    checks++; if (ex_if.EX_valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre: got %b want 1", ex_if.EX_valid_o); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (ex_if.EX_valid_o !== 1'b0 || ex_if.EX_pc_o !== 32'd0) begin
      errors++; $display("FAIL mid_reset: got v=%b pc=%h want 0 0", ex_if.EX_valid_o, ex_if.EX_pc_o); end
    @(negedge clk);
    rst_n = 1'b1; ex_if.EX_ready_i = 1'b1;
  endtask

  initial begin
    ID_valid = 1'b0; instr = 32'h0; ID_pc = 32'h0;
    WB_we = 1'b0; WB_addr = 5'd0; WB_data = 32'h0;
    MEM_rw = 1'b0; MEM_rd = 5'd0;
    ex_if.EX_ready_i = 1'b1;
    test_reset();
    test_load_use();
    test_branch();
    test_jalr();
    test_back_to_back();
    test_backpressure();
    test_wb_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
